// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for load data, extracts/extends it, hands off to WB.
// Optional decode bypass bus is enabled with `define MS_FWD_EN (tied to zero otherwise).
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [203:0] es_to_ms_bus,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [198:0] ms_to_ws_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  input  logic         ws_flush_pipe,
  output logic         ms_ex_to_es,
  output logic [38:0]  ms_to_ds_fwd_bus
);

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  logic         r_ms_valid;
  logic [203:0] r_bus;
  logic         r_buf_valid;
  logic [31:0]  r_buf_data;
  logic [1:0]   r_drop_cnt;

  logic         w_res_from_mem;
  logic [2:0]   w_ld_op;
  logic         w_req_sent;
  logic         w_ex;
  logic         w_ertn;
  logic [31:0]  w_alu_result;
  logic [1:0]   w_addr_lo;

  logic         w_wait_load;
  logic         w_drop_active;
  logic         w_resp_take;
  logic         w_ready_go;
  logic         w_to_ws_fire;
  logic         w_capture;
  logic [1:0]   w_drop_next;

  logic [31:0]  w_raw;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [31:0]  w_load_value;
  logic [31:0]  w_final_result;

  assign w_res_from_mem = r_bus[203];
  assign w_ld_op        = r_bus[202:200];
  assign w_req_sent     = r_bus[199];
  assign w_ex           = r_bus[157];
  assign w_ertn         = r_bus[156];
  assign w_alu_result   = r_bus[63:32];
  assign w_addr_lo      = r_bus[33:32];

  // A response is only ours once every orphan from a flushed load has been swallowed.
  assign w_wait_load   = r_ms_valid && w_res_from_mem && w_req_sent && !w_ex;
  assign w_drop_active = (r_drop_cnt != 2'd0);
  assign w_resp_take   = data_sram_data_ok && !w_drop_active;
  assign w_ready_go    = !w_wait_load || r_buf_valid || w_resp_take;
  assign w_capture     = w_wait_load && !r_buf_valid && w_resp_take;

  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go && !ws_flush_pipe;
  assign w_to_ws_fire   = ms_to_ws_valid && ws_allowin;
  assign ms_ex_to_es    = r_ms_valid && (w_ex || w_ertn);

  always_comb begin
    w_drop_next = r_drop_cnt;
    if (data_sram_data_ok && w_drop_active) begin
      w_drop_next = r_drop_cnt - 2'd1;
    end
    // A flushed load whose response is still in flight leaves an orphan to discard.
    if (ws_flush_pipe && w_wait_load && !r_buf_valid && !w_resp_take && (w_drop_next != 2'd3)) begin
      w_drop_next = w_drop_next + 2'd1;
    end
  end

  // Halfword loads select by address bit 1 only; bit 0 never splits a halfword.
  assign w_raw  = r_buf_valid ? r_buf_data : data_sram_rdata;
  assign w_byte = w_raw[{w_addr_lo, 3'b000} +: 8];
  assign w_half = w_raw[{w_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    w_load_value = w_raw;
    case (w_ld_op)
      LD_B:    w_load_value = {{24{w_byte[7]}}, w_byte};
      LD_BU:   w_load_value = {24'd0, w_byte};
      LD_H:    w_load_value = {{16{w_half[15]}}, w_half};
      LD_HU:   w_load_value = {16'd0, w_half};
      LD_W:    w_load_value = w_raw;
      default: w_load_value = w_raw;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_value : w_alu_result;
  assign ms_to_ws_bus   = {r_bus[198:64], w_final_result, r_bus[31:0]};

`ifdef MS_FWD_EN
  logic       w_gr_we;
  logic [4:0] w_dest;
  assign w_gr_we = r_bus[69];
  assign w_dest  = r_bus[68:64];
  assign ms_to_ds_fwd_bus = {r_ms_valid && w_gr_we && !w_ex,
                             w_wait_load && !w_ready_go,
                             w_dest,
                             w_final_result};
`else
  assign ms_to_ds_fwd_bus = 39'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid  <= 1'b0;
      r_bus       <= 204'd0;
      r_buf_valid <= 1'b0;
      r_buf_data  <= 32'd0;
      r_drop_cnt  <= 2'd0;
    end else begin
      if (ws_flush_pipe) begin
        r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end

      if (!ws_flush_pipe && ms_allowin && es_to_ms_valid) begin
        r_bus <= es_to_ms_bus;
      end

      if (ws_flush_pipe || w_to_ws_fire) begin
        r_buf_valid <= 1'b0;
      end else if (w_capture) begin
        r_buf_valid <= 1'b1;
      end

      if (w_capture) begin
        r_buf_data <= data_sram_rdata;
      end

      r_drop_cnt <= w_drop_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized transactions
// checked against a transaction-level model of load extraction and handshake timing.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [203:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [198:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_flush_pipe;
  logic         ms_ex_to_es;
  logic [38:0]  ms_to_ds_fwd_bus;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_flush_pipe     (ws_flush_pipe),
    .ms_ex_to_es       (ms_ex_to_es),
    .ms_to_ds_fwd_bus  (ms_to_ds_fwd_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [203:0] makeBus(logic res, logic [2:0] ldOp, logic ex, logic ertn,
                                           logic [5:0] ecode, logic grWe, logic [4:0] dest,
                                           logic [31:0] result);
    logic [31:0] vaddr = $urandom();
    logic [31:0] wval  = $urandom();
    logic [31:0] wmask = $urandom();
    logic [31:0] pc    = $urandom();
    logic [8:0]  esub  = 9'($urandom());
    logic [13:0] cnum  = 14'($urandom());
    logic [1:0]  rewe  = 2'($urandom());
    return {res, ldOp, res, vaddr, esub, ex, ertn, wval, ecode, rewe, cnum, wmask,
            grWe, dest, result, pc};
  endfunction

  // Loaded value: pick the addressed byte/halfword out of the word and extend it.
  function automatic logic [31:0] expResult(logic [203:0] bus, logic [31:0] raw);
    logic [31:0] addr = bus[63:32];
    int unsigned byteIdx = addr % 4;
    int unsigned halfIdx = (addr / 2) % 2;
    logic [31:0] v;
    if (!bus[203]) return addr;
    case (bus[202:200])
      3'd1: begin v = (raw >> (8 * byteIdx)) & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
      3'd3: v = (raw >> (8 * byteIdx)) & 32'hFF;
      3'd2: begin v = (raw >> (16 * halfIdx)) & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
      3'd4: v = (raw >> (16 * halfIdx)) & 32'hFFFF;
      default: v = raw;
    endcase
    return v;
  endfunction

  function automatic logic [198:0] expOutBus(logic [203:0] bus, logic [31:0] raw);
    return {bus[198:64], expResult(bus, raw), bus[31:0]};
  endfunction

  function automatic logic [38:0] expFwd(logic [203:0] bus, logic pending, logic [31:0] result);
`ifdef MS_FWD_EN
    return {bus[69] && !bus[157], pending, bus[68:64], result};
`else
    return 39'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic v, logic [203:0] bus, logic wa, logic dok,
                               logic [31:0] rd, logic fl);
    es_to_ms_valid    = v;
    es_to_ms_bus      = bus;
    ws_allowin        = wa;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    ws_flush_pipe     = fl;
    #1;
  endtask

  task automatic checkOutput(string tag, logic [203:0] observed, logic [203:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Stage holds an instruction: compare the handshake, bus, exception flag and bypass.
  task automatic checkStage(string tag, logic [203:0] inBus, logic expValid, logic [31:0] raw,
                            logic expAllow, logic pending);
    logic [198:0] eb = expOutBus(inBus, raw);
    checkOutput({tag, ".valid"}, ms_to_ws_valid, expValid);
    if (expValid) checkOutput({tag, ".bus"}, ms_to_ws_bus, eb);
    checkOutput({tag, ".allowin"}, ms_allowin, expAllow);
    checkOutput({tag, ".ex_to_es"}, ms_ex_to_es, inBus[157] || inBus[156]);
    checkOutput({tag, ".fwd"}, ms_to_ds_fwd_bus, expFwd(inBus, pending, eb[63:32]));
  endtask

  initial begin
    logic [203:0] b;
    logic [31:0]  raw;
    logic         wa;
    logic         res, ex, ertn;
    logic [2:0]   op;
    logic [31:0]  addr;

    reset = 1'b1;
    applyStimulus(0, '0, 0, 0, 0, 0);
    checkOutput("reset.allowin", ms_allowin, 1);
    checkOutput("reset.valid", ms_to_ws_valid, 0);
    checkOutput("reset.ex_to_es", ms_ex_to_es, 0);
    checkOutput("reset.fwd", ms_to_ds_fwd_bus, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // ALU instruction passes straight through
    b = makeBus(0, 3'd0, 0, 0, 6'd0, 1, 5'd5, 32'h1234);
    applyStimulus(1, b, 1, 0, 0, 0);
    checkOutput("alu.entry_allowin", ms_allowin, 1);
    tick();
    applyStimulus(0, '0, 1, 0, 32'h5555_AAAA, 0);
    checkStage("alu", b, 1, 0, 1, 0);
    checkOutput("alu.result", ms_to_ws_bus[63:32], 32'h1234);
    tick();
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("alu.gone", ms_to_ws_valid, 0);

    // ld.b / ld.bu at byte 3, response two cycles after entry
    for (int k = 0; k < 2; k++) begin
      b = makeBus(1, (k == 0) ? 3'd1 : 3'd3, 0, 0, 6'd0, 1, 5'd7, 32'h0000_1003);
      applyStimulus(1, b, 1, 0, 0, 0);
      tick();
      for (int c = 0; c < 2; c++) begin
        applyStimulus(0, '0, 1, 0, $urandom(), 0);
        checkStage("ldb.wait", b, 0, 0, 0, 1);
        tick();
      end
      applyStimulus(0, '0, 1, 1, 32'h80FF_FFFF, 0);
      checkStage("ldb.data", b, 1, 32'h80FF_FFFF, 1, 0);
      checkOutput("ldb.result", ms_to_ws_bus[63:32], (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
      applyStimulus(0, '0, 1, 0, 0, 0);
      checkOutput("ldb.gone", ms_to_ws_valid, 0);
    end

    // ld.hu buffered under backpressure
    b = makeBus(1, 3'd4, 0, 0, 6'd0, 1, 5'd9, 32'h0000_2002);
    applyStimulus(1, b, 1, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 0, 1, 32'hBEEF_0000, 0);
    checkStage("ldhu.data", b, 1, 32'hBEEF_0000, 0, 0);
    tick();
    applyStimulus(0, '0, 0, 0, 32'h1111_2222, 0);
    checkStage("ldhu.stall", b, 1, 32'hBEEF_0000, 0, 0);
    tick();
    applyStimulus(0, '0, 1, 0, 32'h3333_4444, 0);
    checkStage("ldhu.send", b, 1, 32'hBEEF_0000, 1, 0);
    checkOutput("ldhu.result", ms_to_ws_bus[63:32], 32'h0000_BEEF);
    tick();
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("ldhu.once", ms_to_ws_valid, 0);

    // Flush while waiting; the orphan response must not complete the next load
    b = makeBus(1, 3'd0, 0, 0, 6'd0, 1, 5'd3, 32'h0000_3000);
    applyStimulus(1, b, 1, 0, 0, 0);
    tick();
    b = makeBus(1, 3'd0, 0, 0, 6'd0, 1, 5'd4, 32'h0000_4000);
    applyStimulus(1, b, 1, 0, 0, 1);
    checkOutput("flush.valid", ms_to_ws_valid, 0);
    tick();
    applyStimulus(1, b, 1, 0, 0, 0);
    checkOutput("flush.empty_allowin", ms_allowin, 1);
    checkOutput("flush.empty_valid", ms_to_ws_valid, 0);
    tick();
    applyStimulus(0, '0, 1, 1, 32'h0000_DEAD, 0);
    checkStage("flush.orphan", b, 0, 0, 0, 1);
    tick();
    applyStimulus(0, '0, 1, 1, 32'hCAFE_F00D, 0);
    checkStage("flush.own", b, 1, 32'hCAFE_F00D, 1, 0);
    tick();
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("flush.gone", ms_to_ws_valid, 0);

    // Excepting instruction never waits for memory
    b = makeBus(1, 3'd0, 1, 0, 6'h0B, 1, 5'd6, 32'h0000_5000);
    applyStimulus(1, b, 1, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 1, 0, 32'h0000_0042, 0);
    checkStage("ex", b, 1, 32'h0000_0042, 1, 0);
    checkOutput("ex.ecode", ms_to_ws_bus[123:118], 6'h0B);
    checkOutput("ex.flag", ms_to_ws_bus[157], 1);
    tick();
    applyStimulus(0, '0, 1, 0, 0, 0);
    checkOutput("ex.gone", ms_to_ws_valid, 0);

    // Asynchronous reset with a buffered response
    b = makeBus(1, 3'd0, 0, 0, 6'd0, 1, 5'd8, 32'h0000_6000);
    applyStimulus(1, b, 1, 0, 0, 0);
    tick();
    applyStimulus(0, '0, 0, 1, 32'h7777_7777, 0);
    checkStage("rst.buffered", b, 1, 32'h7777_7777, 0, 0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst.allowin", ms_allowin, 1);
    checkOutput("rst.valid", ms_to_ws_valid, 0);
    checkOutput("rst.ex_to_es", ms_ex_to_es, 0);
    checkOutput("rst.fwd", ms_to_ds_fwd_bus, 0);
    tick();
    reset = 1'b0;
    tick();

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      res  = ($urandom() % 3) != 0;
      op   = 3'($urandom());
      ex   = ($urandom() % 8) == 0;
      ertn = !ex && (($urandom() % 10) == 0);
      addr = $urandom();
      if (op == 3'd2 || op == 3'd4) addr[0] = 1'b0;
      b = makeBus(res, op, ex, ertn, 6'($urandom()), 1'($urandom()), 5'($urandom()), addr);
      applyStimulus(1, b, 1, 0, $urandom(), 0);
      checkOutput("rnd.entry_allowin", ms_allowin, 1);
      tick();
      if (res && !ex) begin
        for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
          applyStimulus(0, '0, 1'($urandom()), 0, $urandom(), 0);
          checkStage("rnd.wait", b, 0, 0, 0, 1);
          tick();
        end
        raw = $urandom();
        wa  = 1'($urandom());
        applyStimulus(0, '0, wa, 1, raw, 0);
        checkStage("rnd.data", b, 1, raw, wa, 0);
        tick();
        for (int s = 0; s < 5 && !wa; s++) begin
          wa = (s == 4) ? 1'b1 : 1'($urandom());
          applyStimulus(0, '0, wa, 0, $urandom(), 0);
          checkStage("rnd.buf", b, 1, raw, wa, 0);
          tick();
        end
      end else begin
        wa = 1'b0;
        for (int s = 0; s < 5 && !wa; s++) begin
          wa  = (s == 4) ? 1'b1 : 1'($urandom());
          raw = $urandom();
          applyStimulus(0, '0, wa, 0, raw, 0);
          checkStage("rnd.pass", b, 1, raw, wa, 0);
          tick();
        end
      end
      applyStimulus(0, '0, 1, 0, 0, 0);
      checkOutput("rnd.gone", ms_to_ws_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
